unipolar_rz_decoder: RTL

UNIPOLAR_RZ_DECODER -- requirements
Module: unipolar_rz_decoder

---
 rtl/unipolar_rz_decoder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/unipolar_rz_decoder.sv
// -----------------------------------------------------------------------------
// unipolar_rz_decoder
//
// Decodes a unipolar return-to-zero serial line (WS2812-style) into words.
// Each bit is a high pulse followed by low time; the high-pulse length decides
// the bit value. A long low period marks a frame boundary.
//
// Ports
//   clock     : sole clock, all logic on the rising edge
//   reset_n   : asynchronous active-low reset
//   line      : asynchronous serial input (synchronised internally)
//   data      : last completed word, LSB received first
//   valid     : one-cycle pulse when data updates
//   frame_end : one-cycle pulse when a reset-length low period completes
//   error     : one-cycle pulse on a protocol violation
//
// Configuration
//   UNIPOLAR_RZ_DECODER_ERROR_EN : when defined, too-short and too-long high
//   pulses and partial words at a frame boundary raise error. When undefined,
//   error is tied low, short highs decode as 0 and long highs as 1.
// -----------------------------------------------------------------------------
module unipolar_rz_decoder #(
    parameter int  DATA_WIDTH     = 24,
    parameter real CLOCK_RATE     = 100e6,
    parameter real ZERO_HIGH_TIME = 0.3e-6,
    parameter real ONE_HIGH_TIME  = 0.6e-6,
    parameter real RESET_TIME     = 80e-6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_end,
    output logic                  error
);

    // Cycle-count constants, rounded to nearest integer.
    localparam int THRESH       = $rtoi((ZERO_HIGH_TIME + ONE_HIGH_TIME) / 2.0 * CLOCK_RATE + 0.5);
    localparam int RESET_CYCLES = $rtoi(RESET_TIME * CLOCK_RATE + 0.5);
    localparam int CNT_W        = $clog2(RESET_CYCLES + 1);
    localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] RESET_CNT  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(THRESH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

`ifdef UNIPOLAR_RZ_DECODER_ERROR_EN
    localparam int MIN_HIGH = $rtoi(ZERO_HIGH_TIME / 2.0 * CLOCK_RATE + 0.5);
    localparam int MAX_HIGH = $rtoi(ONE_HIGH_TIME * 1.5 * CLOCK_RATE + 0.5);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HIGH);
`endif

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        LOW       = 2'd1,
        HIGH      = 2'd2
    } state_t;

    // Saturating increment: the counter sticks at RESET_CYCLES, never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == RESET_CNT) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic                  sync1_r;
    logic                  sync_r;
    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  done_r;
    logic                  fe_pend_r;
    logic                  err_pend_r;

    logic [CNT_W-1:0]      cnt_inc_s;
    logic                  bit_s;
    logic [DATA_WIDTH-1:0] shift_nxt_s;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync_r  <= 1'b0;
        end else begin
            sync1_r <= line;
            sync_r  <= sync1_r;
        end
    end

    // Next counter value and the bit the current high pulse would decode to.
    always_comb begin
        cnt_inc_s   = sat_inc(cnt_r);
        bit_s       = (cnt_r >= THRESH_CNT);
        shift_nxt_s = {bit_s, shift_r[DATA_WIDTH-1:1]};
    end

    // Decode FSM: one counter serves idle/low/high timing depending on state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= WAIT_IDLE;
            cnt_r      <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            done_r     <= 1'b0;
            fe_pend_r  <= 1'b0;
            err_pend_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            fe_pend_r  <= 1'b0;
            err_pend_r <= 1'b0;
            case (state_r)
                WAIT_IDLE: begin
                    if (sync_r) begin
                        cnt_r <= '0;
                    end else if (cnt_inc_s == RESET_CNT) begin
                        // Idle found: enter LOW already saturated so no frame_end fires.
                        state_r   <= LOW;
                        cnt_r     <= RESET_CNT;
                        bit_cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                LOW: begin
                    if (sync_r) begin
                        state_r <= HIGH;
                        cnt_r   <= '0;
                    end else if (cnt_r != RESET_CNT) begin
                        cnt_r <= cnt_inc_s;
                        if (cnt_inc_s == RESET_CNT) begin
                            fe_pend_r <= 1'b1;
                            bit_cnt_r <= '0;
`ifdef UNIPOLAR_RZ_DECODER_ERROR_EN
                            err_pend_r <= (bit_cnt_r != '0);
`endif
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                HIGH: begin
                    if (sync_r) begin
`ifdef UNIPOLAR_RZ_DECODER_ERROR_EN
                        if (cnt_inc_s >= MAX_CNT) begin
                            err_pend_r <= 1'b1;
                            state_r    <= WAIT_IDLE;
                            cnt_r      <= '0;
                            bit_cnt_r  <= '0;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
`else
                        cnt_r <= cnt_inc_s;
`endif
                    end else begin
                        state_r <= LOW;
                        cnt_r   <= '0;
`ifdef UNIPOLAR_RZ_DECODER_ERROR_EN
                        if (cnt_r < MIN_CNT) begin
                            // Glitch-length pulse: drop it and restart the word.
                            err_pend_r <= 1'b1;
                            bit_cnt_r  <= '0;
                        end else
`endif
                        begin
                            shift_r <= shift_nxt_s;
                            if (bit_cnt_r == LAST_BIT) begin
                                done_r    <= 1'b1;
                                bit_cnt_r <= '0;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= WAIT_IDLE;
                    cnt_r     <= '0;
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

    // Registered outputs; data loads from the completed shift register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_end <= 1'b0;
            error     <= 1'b0;
        end else begin
            valid     <= done_r;
            frame_end <= fe_pend_r;
            error     <= err_pend_r;
            if (done_r) begin
                data <= shift_r;
            end else begin
                data <= data;
            end
        end
    end

endmodule
